adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Synthesizable SPI responder that plays the ADC side of the 12-bit ADC serial link: it answers the existing `spi_interface` master (sclk/cs_n/saddr in, sdat out) with 16-clock frames carrying a held 12-bit sample. It also decodes the 3-bit channel address the master shifts in on saddr. It sits on the FPGA fabric in place of the external converter, for loopback bring-up, hardware-in-the-loop tests and as a reusable peer model. All SPI inputs are oversampled in the single `clk` domain.

## Interface
Parameters:
- `DATA_W`, 12, sample width.
- `FRAME_LEN`, 16, sclk rising edges per frame.
- `LEAD_ZEROS`, 4, zero bits sent before the sample MSB; must equal `FRAME_LEN - DATA_W`.
- `ADDR_FIRST`, 3, 1-based rising-edge index of the first address bit; ADD2, ADD1 and ADD0 are captured on edges 3, 4 and 5.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `cs_n` in 1: frame select, active-low, asynchronous.
- `saddr` in 1: master address line, sampled on sclk rising edges.
- `adc_value` in `DATA_W`: live sample, held at frame start.
- `sdat` out 1: serial data to master, MSB first.
- `channel` out 3: address decoded from the last complete frame.
- `frame_done` out 1: one-`clk` pulse when a complete frame ends.
- `frame_error` out 1: one-`clk` pulse when cs_n rises before `FRAME_LEN` rising edges.
- `busy` out 1: high while a frame is active.

## Operation
- Input conditioning: sclk, cs_n and saddr each pass through a 2-FF synchronizer. sclk and cs_n also get a third register for edge detection, producing `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.
- State machine: IDLE, SHIFT, HOLD.
- IDLE to SHIFT on `cs_fall`:
  - latch `adc_value` into `shreg = {LEAD_ZEROS'b0, adc_value}`;
  - clear edge count `cnt` and the address register;
  - drive `sdat = shreg[15]`, which is 0.
- In SHIFT, on `sclk_rise`:
  - `cnt <= cnt + 1`;
  - if the new `cnt` is in 3..5, shift synchronized saddr into `addr_sr`.
- In SHIFT, on `sclk_fall` with `cnt >= 1`: shift `shreg` left and drive the next bit on `sdat`. A falling edge before the first rise is ignored.
- When `cnt` reaches `FRAME_LEN`, go to HOLD; `sdat` drives the LSB until the next `sclk_fall`, then 0.
- HOLD to IDLE on `cs_rise`: `channel <= addr_sr`, `frame_done` pulses. Further sclk edges in HOLD have no effect and keep sdat 0.
- SHIFT to IDLE on `cs_rise` (abort): `frame_error` pulses, `channel` is unchanged, `sdat` goes to 0.
- `cs_rise` and `sclk_rise` in the same cycle: the edge counts first, then the cs rule applies. This makes a 16th edge coincident with cs_rise a valid frame.
- `adc_value` changes during a frame do not affect the frame in flight.
- `cnt` is 5 bits, saturates at `FRAME_LEN` and never wraps.
- Reset values: state IDLE, `sdat` 0, `channel` 0, `frame_done` 0, `frame_error` 0, `busy` 0, `cnt` 0, `shreg` 0. Synchronizers reset to the idle line levels: sclk 1, cs_n 1, saddr 0.
- Reset mid-frame: return to IDLE next cycle with no pulses. A frame already in progress is not resumed; the next frame starts only on a fresh `cs_fall`.

## Timing
- Pin to internal edge detection: 3 `clk` cycles of latency, so `sdat` updates 3–4 `clk` after the pin-level sclk falling edge.
- Constraint: sclk high and low phases are each at least 4 `clk`. The supported maximum is sclk ≤ clk/8.
- At frame start, the first `sdat` value is valid 4 `clk` after cs_n falls.
- `frame_done` and `frame_error` assert 4 `clk` after cs_n rises at the pin.
- `channel` is updated in the same cycle as `frame_done`.
- `busy` is high from the cycle after `cs_fall` through the cycle of `cs_rise`.

## Structure
- Shared include `adc_spi_defs.vh` holds:
  - `DATA_W`, `FRAME_LEN`, `LEAD_ZEROS` and the address edge indices;
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_HOLD`.
  - `spi_interface` uses the same frame constants from this file.
- One sub-module, `sync_edge`: 2-FF synchronizer plus edge register with parameterized reset level and `rise`/`fall` outputs. It is instantiated for sclk and cs_n; saddr uses the synchronizer part only.

## Test plan
- `adc_value`=2237 (0x8BD), saddr bits 1,0,1 on edges 3–5, sclk = clk/100 -> `sdat` bit stream 0000_1000_1011_1101; `channel`=5; one `frame_done` pulse; no `frame_error`.
- Back-to-back frames with `adc_value` 2237, 2239, 2234, 2231 and 3 idle sclk periods between frames -> `spi_interface` `data_out` matches each value in order with `end_of_conversion` per frame; `channel` is stable.
- `adc_value` changed from 2237 to 0 after edge 6 -> the remaining bits still follow 2237; the next frame sends 0.
- cs_n raised after 7 rising edges with saddr 1,1,1 -> `frame_error` pulse; `channel` keeps its previous value (5); `sdat` is 0; the next frame succeeds.
- `reset` asserted at edge 9 and released -> all outputs 0 next cycle; no pulses; the following full frame is correct.
- 20 sclk edges within one cs_n low window -> bits after the 16th are 0; `cnt` saturates; one `frame_done` at cs_n rise.

Source files
------------

// File: rtl/adc_spi_responder_pkg.sv
// Shared frame constants, FSM encodings and helpers for the ADC-side SPI responder.
// Any peer master model should take its frame geometry from here as well.
package adc_spi_responder_pkg;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_FRAME_LEN  = 16;
  localparam int DEF_LEAD_ZEROS = DEF_FRAME_LEN - DEF_DATA_W;
  localparam int DEF_ADDR_FIRST = 3;
  localparam int ADDR_W         = 3;
  localparam int CNT_W          = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // True when a 1-based rising-edge index falls inside [lo, hi].
  function automatic logic in_window(input logic [CNT_W-1:0] idx, input int lo, input int hi);
    return (int'(idx) >= lo) && (int'(idx) <= hi);
  endfunction

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Two-flop synchronizer plus history register with registered rise/fall pulses.
// Edges are masked for a few cycles after reset so a line already away from its idle level is not mistaken for an edge.
module adc_spi_responder_sync_edge #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic       meta_reg;
  logic       sync_reg;
  logic       last_reg;
  logic       rise_reg;
  logic       fall_reg;
  logic [1:0] fill_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RESET_LEVEL;
      sync_reg <= RESET_LEVEL;
      last_reg <= RESET_LEVEL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      fill_reg <= 2'd3;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      last_reg <= sync_reg;
      if (fill_reg != 2'd0) begin
        fill_reg <= fill_reg - 2'd1;
      end
      rise_reg <= (fill_reg == 2'd0) && sync_reg && !last_reg;
      fall_reg <= (fill_reg == 2'd0) && !sync_reg && last_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder: serves a held sample as a fixed-length MSB-first frame and
// decodes the channel address shifted in on saddr. All SPI pins are oversampled on clk.
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
  parameter int ADDR_FIRST = DEF_ADDR_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              saddr,
  input  logic [DATA_W-1:0] adc_value,
  output logic              sdat,
  output logic [2:0]        channel,
  output logic              frame_done,
  output logic              frame_error,
  output logic              busy
);

  logic [1:0] line_pin;
  logic [1:0] line_rise;
  logic [1:0] line_fall;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_rise;
  logic       cs_fall;

  assign line_pin = {cs_n, sclk};

  // Both sclk and cs_n idle high, so both conditioners reset to 1.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      adc_spi_responder_sync_edge #(
        .RESET_LEVEL(1'b1)
      ) u_sync_edge (
        .clk  (clk),
        .reset(reset),
        .din  (line_pin[gi]),
        .rise (line_rise[gi]),
        .fall (line_fall[gi])
      );
    end
  endgenerate

  assign sclk_rise = line_rise[0];
  assign sclk_fall = line_fall[0];
  assign cs_rise   = line_rise[1];
  assign cs_fall   = line_fall[1];

  logic saddr_meta_reg;
  logic saddr_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      saddr_meta_reg <= 1'b0;
      saddr_sync_reg <= 1'b0;
    end else begin
      saddr_meta_reg <= saddr;
      saddr_sync_reg <= saddr_meta_reg;
    end
  end

  logic [1:0]           state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic [FRAME_LEN-1:0] shreg_reg;
  logic [FRAME_LEN-1:0] frame_load;
  logic [ADDR_W-1:0]    addr_sr_reg;
  logic [ADDR_W-1:0]    addr_next;
  logic                 frame_full;
  logic                 sdat_reg;
  logic [2:0]           channel_reg;
  logic                 frame_done_reg;
  logic                 frame_error_reg;

  assign frame_load = {{LEAD_ZEROS{1'b0}}, adc_value};

  // The edge count is resolved before any cs rule so a 16th edge coincident with cs_rise still completes the frame.
  always_comb begin
    cnt_next  = cnt_reg;
    addr_next = addr_sr_reg;
    if (sclk_rise && (cnt_reg != CNT_W'(FRAME_LEN))) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (in_window(cnt_next, ADDR_FIRST, ADDR_FIRST + ADDR_W - 1)) begin
        addr_next = {addr_sr_reg[ADDR_W-2:0], saddr_sync_reg};
      end
    end
  end

  assign frame_full = (cnt_next == CNT_W'(FRAME_LEN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      shreg_reg       <= '0;
      addr_sr_reg     <= '0;
      sdat_reg        <= 1'b0;
      channel_reg     <= '0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cs_fall) begin
            shreg_reg   <= frame_load;
            cnt_reg     <= '0;
            addr_sr_reg <= '0;
            sdat_reg    <= frame_load[FRAME_LEN-1];
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt_reg     <= cnt_next;
          addr_sr_reg <= addr_next;
          // A falling edge before the first rise is the master parking sclk, not a bit boundary.
          if (sclk_fall && (cnt_reg != '0)) begin
            shreg_reg <= {shreg_reg[FRAME_LEN-2:0], 1'b0};
            sdat_reg  <= shreg_reg[FRAME_LEN-2];
          end
          if (cs_rise) begin
            sdat_reg  <= 1'b0;
            state_reg <= ST_IDLE;
            if (frame_full) begin
              channel_reg    <= addr_next;
              frame_done_reg <= 1'b1;
            end else begin
              frame_error_reg <= 1'b1;
            end
          end else if (frame_full) begin
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (sclk_fall) begin
            sdat_reg <= 1'b0;
          end
          if (cs_rise) begin
            channel_reg    <= addr_sr_reg;
            frame_done_reg <= 1'b1;
            sdat_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdat        = sdat_reg;
  assign channel     = channel_reg;
  assign frame_done  = frame_done_reg;
  assign frame_error = frame_error_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI master and compares sdat bits, pulses and
// channel against a frame-level model ({zeros, sample} MSB first, address from edges 3..5).
module tb_adc_spi_responder;

  localparam int HALF = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        cs_n;
  logic        saddr;
  logic [11:0] adc_value;
  logic        sdat;
  logic [2:0]  channel;
  logic        frame_done;
  logic        frame_error;
  logic        busy;

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [2:0]  exp_channel   = 3'd0;
  int          frame_no      = 0;

  always #5 clk = ~clk;

  adc_spi_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .saddr      (saddr),
    .adc_value  (adc_value),
    .sdat       (sdat),
    .channel    (channel),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master transaction. change_at/reset_at are 1-based rising-edge indices (0 = never).
  task automatic run_frame(input logic [11:0] value, input logic [2:0] addr, input int n_edges,
                           input int change_at, input logic [11:0] new_value, input int reset_at);
    logic [15:0] frame_bits;
    logic [15:0] got_bits;
    int          exp_bit;
    int          bit_errs;
    int          done_cnt;
    int          err_cnt;
    int          pulse_at;
    int          chan_at_pulse;
    logic        dead;
    logic        want_done;
    logic        want_err;

    frame_bits = {4'b0000, value};
    got_bits   = '0;
    bit_errs   = 0;
    dead       = 1'b0;
    adc_value  = value;
    cs_n       = 1'b0;
    wait_clks(6);
    check_val("busy_start", busy, 1);

    for (int k = 1; k <= n_edges; k++) begin
      sclk  = 1'b0;
      saddr = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom_range(0, 1));
      wait_clks(HALF);
      exp_bit = (dead || k > 16) ? 0 : int'(frame_bits[16-k]);
      if (k <= 16) got_bits[16-k] = sdat;
      if (sdat !== 1'(exp_bit)) bit_errs++;
      check_val($sformatf("sdat_edge%0d", k), sdat, exp_bit);
      sclk = 1'b1;
      if (k == change_at) adc_value = new_value;
      if (k == reset_at) begin
        wait_clks(2);
        reset = 1'b1;
        wait_clks(1);
        check_val("rst_sdat", sdat, 0);
        check_val("rst_channel", channel, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_error", frame_error, 0);
        reset       = 1'b0;
        dead        = 1'b1;
        exp_channel = 3'd0;
        wait_clks(HALF - 3);
      end else begin
        wait_clks(HALF);
      end
    end

    want_done = !dead && (n_edges >= 16);
    want_err  = !dead && (n_edges < 16);
    done_cnt      = 0;
    err_cnt       = 0;
    pulse_at      = 0;
    chan_at_pulse = 0;
    cs_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        if (pulse_at == 0) begin
          pulse_at      = c;
          chan_at_pulse = int'(channel);
        end
      end
      if (frame_error) begin
        err_cnt++;
        if (pulse_at == 0) pulse_at = c;
      end
    end
    if (want_done) exp_channel = addr;

    check_val("done_pulses", done_cnt, int'(want_done));
    check_val("error_pulses", err_cnt, int'(want_err));
    if (want_done || want_err) check_val("pulse_latency", pulse_at, 4);
    if (want_done) check_val("channel_with_done", chan_at_pulse, int'(addr));
    check_val("channel_after", channel, exp_channel);
    check_val("sdat_after", sdat, 0);
    check_val("busy_after", busy, 0);

    frame_no++;
    $display("frame %0d: value=0x%03h addr=%0d edges=%0d change_at=%0d reset_at=%0d bits=%04h bit_errs=%0d done=%0d error=%0d channel=%0d",
             frame_no, value, addr, n_edges, change_at, reset_at, got_bits, bit_errs,
             done_cnt, err_cnt, channel);
    wait_clks(HALF * 6);
  endtask

  initial begin
    reset     = 1'b1;
    sclk      = 1'b1;
    cs_n      = 1'b1;
    saddr     = 1'b0;
    adc_value = '0;
    wait_clks(3);
    check_val("reset_sdat", sdat, 0);
    check_val("reset_channel", channel, 0);
    check_val("reset_done", frame_done, 0);
    check_val("reset_error", frame_error, 0);
    check_val("reset_busy", busy, 0);
    reset = 1'b0;
    wait_clks(8);

    // Directed cases
    run_frame(12'd2237, 3'd5, 16, 0, 12'd0, 0);
    run_frame(12'd2239, 3'd5, 16, 0, 12'd0, 0);
    run_frame(12'd2234, 3'd5, 16, 0, 12'd0, 0);
    run_frame(12'd2231, 3'd5, 16, 0, 12'd0, 0);
    run_frame(12'd2237, 3'd5, 16, 6, 12'd0, 0);
    run_frame(12'd0,    3'd5, 16, 0, 12'd0, 0);
    run_frame(12'd2237, 3'd7, 7,  0, 12'd0, 0);
    run_frame(12'd2237, 3'd3, 16, 0, 12'd0, 0);
    run_frame(12'd1234, 3'd6, 16, 0, 12'd0, 9);
    run_frame(12'd4095, 3'd2, 16, 0, 12'd0, 0);
    run_frame(12'd2237, 3'd4, 20, 0, 12'd0, 0);

    // Randomized frames, some aborted, some with mid-frame sample changes
    for (int i = 0; i < 10; i++) begin
      run_frame(12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)),
                int'($urandom_range(12, 20)), int'($urandom_range(0, 16)),
                12'($urandom_range(0, 4095)), 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
